// File: rtl/rf_write_arbiter_pkg.sv
// Shared types for the register-file write-back path: default widths,
// the queued write request and the arbiter state encoding.
package rf_pkg;

  localparam int ADDR  = 5;
  localparam int BUS_W = 32;

  typedef struct packed {
    logic [ADDR-1:0]  addr;
    logic [BUS_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } wb_state_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Write-back bundle: ALU and MDU producers in, register-file write port and
// pending-destination mask out. master drives producers, slave is the arbiter.
interface rf_write_arbiter_if #(
  parameter int ADDR  = 5,
  parameter int BUS_W = 32
) ();

  logic              alu_valid;
  logic [ADDR-1:0]   alu_addr;
  logic [BUS_W-1:0]  alu_data;
  logic              alu_stall;

  logic              mdu_issue;
  logic [ADDR-1:0]   mdu_issue_addr;
  logic              mdu_valid;
  logic              mdu_ready;
  logic [ADDR-1:0]   mdu_addr;
  logic [BUS_W-1:0]  mdu_data;

  logic              r_write;
  logic [ADDR-1:0]   rd_addr;
  logic [BUS_W-1:0]  rd_w_data;
  logic [2**ADDR-1:0] pend_mask;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mdu_issue, mdu_issue_addr, mdu_valid, mdu_addr, mdu_data,
    input  alu_stall, mdu_ready, r_write, rd_addr, rd_w_data, pend_mask
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mdu_issue, mdu_issue_addr, mdu_valid, mdu_addr, mdu_data,
    output alu_stall, mdu_ready, r_write, rd_addr, rd_w_data, pend_mask
  );

endinterface

// File: rtl/rf_write_arbiter_wb_fifo.sv
// In-order FIFO of write-back requests; head is visible combinationally,
// push while full and pop while empty are ignored.
module wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_req_t                push_req,
  input  logic                   pop,
  output wb_req_t                head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_q, rd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               push_ok, pop_ok;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_q];
  assign count   = cnt_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + PTR_W'(1);
      if (pop_ok)  rd_q <= rd_q + PTR_W'(1);
      if (push_ok && !pop_ok)      cnt_q <= cnt_q + CNT_W'(1);
      else if (pop_ok && !push_ok) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_req;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Owns the register-file write port: ALU results win in NORMAL, queued MDU
// results win in DRAIN; also tracks MDU destinations not yet committed.
module rf_write_arbiter #(
  parameter int ADDR  = 5,
  parameter int BUS_W = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  rf_write_arbiter_if.slave bus
);
  import rf_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_state_t          state_q;
  logic [CNT_W-1:0]   count, count_d;
  logic               full, empty;
  wb_req_t            head, push_req;
  logic               alu_take, fifo_pop, fifo_push;

  logic               r_write_q, r_write_d;
  logic [ADDR-1:0]    rd_addr_q, rd_addr_d;
  logic [BUS_W-1:0]   rd_w_data_q, rd_w_data_d;
  logic [2**ADDR-1:0] pend_q, pend_d;

  // Ready/stall look only at registered state so no valid-to-ready path exists.
  assign bus.mdu_ready = rst && !full;
  assign bus.alu_stall = rst && (state_q == DRAIN);

  assign alu_take  = (state_q == NORMAL) && bus.alu_valid && (bus.alu_addr != '0);
  assign fifo_pop  = !empty && !alu_take;
  assign fifo_push = bus.mdu_valid && bus.mdu_ready && (bus.mdu_addr != '0);
  assign push_req  = '{addr: bus.mdu_addr, data: bus.mdu_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_req (push_req),
    .pop      (fifo_pop),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    count_d = count;
    if (fifo_push && !fifo_pop)      count_d = count + CNT_W'(1);
    else if (fifo_pop && !fifo_push) count_d = count - CNT_W'(1);

    r_write_d   = alu_take || fifo_pop;
    rd_addr_d   = rd_addr_q;
    rd_w_data_d = rd_w_data_q;
    if (alu_take) begin
      rd_addr_d   = bus.alu_addr;
      rd_w_data_d = bus.alu_data;
    end else if (fifo_pop) begin
      rd_addr_d   = head.addr;
      rd_w_data_d = head.data;
    end

    // Issue is applied after the commit clear so a same-cycle set wins.
    pend_d = pend_q;
    if (fifo_pop)      pend_d[head.addr] = 1'b0;
    if (bus.mdu_issue) pend_d[bus.mdu_issue_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= NORMAL;
      r_write_q   <= 1'b0;
      rd_addr_q   <= '0;
      rd_w_data_q <= '0;
      pend_q      <= '0;
    end else begin
      case (state_q)
        NORMAL:  if (count_d == CNT_W'(DEPTH)) state_q <= DRAIN;
        DRAIN:   if (count_d == '0)            state_q <= NORMAL;
        default: state_q <= NORMAL;
      endcase
      r_write_q   <= r_write_d;
      rd_addr_q   <= rd_addr_d;
      rd_w_data_q <= rd_w_data_d;
      pend_q      <= pend_d;
    end
  end

  assign bus.r_write   = r_write_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.rd_w_data = rd_w_data_q;
  assign bus.pend_mask = pend_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: inputs change just after the falling
// edge, outputs are sampled at the falling edge (or #1 after async reset).
module tb_rf_write_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  rf_write_arbiter_if #(.ADDR(5), .BUS_W(32)) bus ();

  rf_write_arbiter #(.ADDR(5), .BUS_W(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.mdu_issue = 1'b0; bus.mdu_issue_addr = '0;
    bus.mdu_valid = 1'b0; bus.mdu_addr = '0; bus.mdu_data = '0;
  endtask

  task automatic alu(input logic [4:0] a, input logic [31:0] d);
    bus.alu_valid = 1'b1; bus.alu_addr = a; bus.alu_data = d;
  endtask

  task automatic mdu(input logic [4:0] a, input logic [31:0] d);
    bus.mdu_valid = 1'b1; bus.mdu_addr = a; bus.mdu_data = d;
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    // Reset values
    chk("rst_r_write", bus.r_write, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_rd_w_data", bus.rd_w_data, 0);
    chk("rst_pend", bus.pend_mask, 0);
    chk("rst_mdu_ready", bus.mdu_ready, 0);
    chk("rst_alu_stall", bus.alu_stall, 0);
    rst = 1'b1;
    #1;
    chk("rel_mdu_ready", bus.mdu_ready, 1);
    chk("rel_alu_stall", bus.alu_stall, 0);
    @(negedge clk);

    // ALU write, then ALU write to x0 is dropped
    alu(5'd3, 32'hDEADBEEF);
    tick();
    chk("alu_r_write", bus.r_write, 1);
    chk("alu_rd_addr", bus.rd_addr, 3);
    chk("alu_rd_data", bus.rd_w_data, 32'hDEADBEEF);
    alu(5'd0, 32'h55);
    tick();
    chk("alu0_r_write", bus.r_write, 0);
    chk("alu0_hold_addr", bus.rd_addr, 3);
    chk("alu0_hold_data", bus.rd_w_data, 32'hDEADBEEF);
    idle_inputs();

    // MDU issue, result, commit one cycle after enqueue
    bus.mdu_issue = 1'b1; bus.mdu_issue_addr = 5'd7;
    tick();
    bus.mdu_issue = 1'b0;
    chk("issue7_pend", bus.pend_mask, 32'h80);
    mdu(5'd7, 32'h1234);
    tick();
    bus.mdu_valid = 1'b0;
    chk("enq7_no_bypass", bus.r_write, 0);
    chk("enq7_pend_held", bus.pend_mask[7], 1);
    tick();
    chk("mdu7_r_write", bus.r_write, 1);
    chk("mdu7_rd_addr", bus.rd_addr, 7);
    chk("mdu7_rd_data", bus.rd_w_data, 32'h1234);
    chk("mdu7_pend_clr", bus.pend_mask, 0);
    tick();
    chk("mdu7_single", bus.r_write, 0);

    // Fill to DEPTH under continuous ALU traffic, then drain in order
    alu(5'd9, 32'h900);
    for (int i = 1; i <= 4; i++) begin
      mdu(5'(i), 32'h100 * i + 1);
      tick();
      chk($sformatf("fill%0d_alu_addr", i), bus.rd_addr, 9);
      chk($sformatf("fill%0d_ready", i), bus.mdu_ready, (i < 4) ? 1 : 0);
      chk($sformatf("fill%0d_stall", i), bus.alu_stall, (i < 4) ? 0 : 1);
    end
    bus.mdu_valid = 1'b0;
    alu(5'd12, 32'hC00);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("drain%0d_r_write", i), bus.r_write, 1);
      chk($sformatf("drain%0d_addr", i), bus.rd_addr, i);
      chk($sformatf("drain%0d_data", i), bus.rd_w_data, 32'h100 * i + 1);
      chk($sformatf("drain%0d_stall", i), bus.alu_stall, (i < 4) ? 1 : 0);
    end
    tick();
    chk("held_alu_addr", bus.rd_addr, 12);
    chk("held_alu_data", bus.rd_w_data, 32'hC00);
    idle_inputs();

    // Count 2, then six cycles of simultaneous enqueue/dequeue across wrap
    alu(5'd9, 32'h900);
    mdu(5'd16, 32'h50);
    tick();
    mdu(5'd17, 32'h51);
    tick();
    bus.alu_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      mdu(5'(18 + k), 32'h52 + k);
      tick();
      chk($sformatf("ovl%0d_addr", k), bus.rd_addr, 16 + k);
      chk($sformatf("ovl%0d_data", k), bus.rd_w_data, 32'h50 + k);
      chk($sformatf("ovl%0d_ready", k), bus.mdu_ready, 1);
    end
    bus.mdu_valid = 1'b0;
    for (int k = 6; k < 8; k++) begin
      tick();
      chk($sformatf("tail%0d_addr", k), bus.rd_addr, 16 + k);
      chk($sformatf("tail%0d_data", k), bus.rd_w_data, 32'h50 + k);
    end
    tick();
    chk("ovl_empty", bus.r_write, 0);

    // Commit of addr 5 coinciding with a new issue to addr 5
    bus.mdu_issue = 1'b1; bus.mdu_issue_addr = 5'd5;
    tick();
    bus.mdu_issue = 1'b0;
    mdu(5'd5, 32'h55);
    tick();
    bus.mdu_valid = 1'b0;
    bus.mdu_issue = 1'b1; bus.mdu_issue_addr = 5'd5;
    tick();
    chk("race5_commit", bus.rd_addr, 5);
    chk("race5_pend", bus.pend_mask[5], 1);
    bus.mdu_issue_addr = 5'd0;
    tick();
    bus.mdu_issue = 1'b0;
    chk("x0_pend", bus.pend_mask, 32'h20);

    // Asynchronous reset with three entries queued
    alu(5'd9, 32'h999);
    bus.mdu_issue = 1'b1; bus.mdu_issue_addr = 5'd20;
    for (int i = 0; i < 3; i++) begin
      mdu(5'(20 + i), 32'hE0 + i);
      tick();
      bus.mdu_issue = 1'b0;
    end
    chk("pre_rst_r_write", bus.r_write, 1);
    chk("pre_rst_pend", bus.pend_mask, 32'h0010_0020);
    rst = 1'b0;
    #1;
    chk("arst_r_write", bus.r_write, 0);
    chk("arst_pend", bus.pend_mask, 0);
    chk("arst_rd_addr", bus.rd_addr, 0);
    chk("arst_mdu_ready", bus.mdu_ready, 0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post_rst_idle", bus.r_write, 0);
    mdu(5'd6, 32'h66);
    tick();
    bus.mdu_valid = 1'b0;
    chk("post_rst_enq", bus.r_write, 0);
    tick();
    chk("post_rst_addr", bus.rd_addr, 6);
    chk("post_rst_data", bus.rd_w_data, 32'h66);
    tick();
    chk("post_rst_no_stale", bus.r_write, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Write-back stage that sits directly upstream of the register file and owns its single write port (`r_write`, `rd_addr`, `rd_w_data`). It merges single-cycle ALU results with results from the multi-cycle multiply/divide unit (MDU), buffering MDU results in a small in-order FIFO. It also keeps a pending-destination scoreboard so the hazard unit can stall readers of registers whose MDU result has not yet committed.

## Interface
- `ADDR`, 5, register address width
- `BUS_W`, 32, data width
- `DEPTH`, 4, MDU result FIFO entries (power of two, ≥2)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset; asynchronous, active-low
- `alu_valid`  in  1  ALU result present this cycle
- `alu_addr`  in  ADDR  ALU destination
- `alu_data`  in  BUS_W  ALU result
- `alu_stall`  out  1  ALU write not accepted this cycle; upstream holds
- `mdu_issue`  in  1  MDU operation issued (pulse)
- `mdu_issue_addr`  in  ADDR  destination of issued MDU op
- `mdu_valid`  in  1  MDU result offered
- `mdu_ready`  out  1  FIFO can accept an MDU result
- `mdu_addr`  in  ADDR  MDU result destination
- `mdu_data`  in  BUS_W  MDU result
- `r_write`  out  1  register-file write enable (registered)
- `rd_addr`  out  ADDR  register-file write address (registered)
- `rd_w_data`  out  BUS_W  register-file write data (registered)
- `pend_mask`  out  2**ADDR  bit i set: MDU write to register i outstanding

## Operation
- Reset (`rst`=0): FIFO empty, count 0, state NORMAL, `r_write`/`rd_addr`/`rd_w_data`/`pend_mask` all 0. `mdu_ready` and `alu_stall` are forced to 0 while `rst` is low.
- FSM with two states:
  - NORMAL: ALU has priority; `alu_stall`=0.
  - DRAIN: FIFO has priority; `alu_stall`=1.
  - NORMAL→DRAIN when count reaches DEPTH. DRAIN→NORMAL when count reaches 0.
- Write selection, one commit per cycle:
  - NORMAL: if `alu_valid` and `alu_addr`≠0, commit the ALU write. Otherwise, if the FIFO is non-empty, commit the FIFO head.
  - DRAIN: commit the FIFO head. ALU input is ignored.
- ALU writes to address 0 are dropped: no `r_write`, and the FIFO may use that cycle.
- Enqueue: on `mdu_valid && mdu_ready`. `mdu_ready` = count < DEPTH and is not relieved by a same-cycle dequeue. An MDU result to address 0 is accepted and discarded, not queued.
- Simultaneous enqueue and dequeue: count is unchanged, and both pointers advance modulo DEPTH.
- Scoreboard:
  - `mdu_issue` with address ≠0 sets the `pend_mask` bit.
  - Committing a FIFO entry clears the bit for its address.
  - If a set and a clear hit the same bit in one cycle, the set wins.
  - Bit 0 is always 0.
- The FIFO commits strictly in enqueue order.

## Timing
- ALU write: inputs at edge N → `r_write`=1 with address/data valid after edge N; the register file captures it at edge N+1.
- MDU write: enqueued at edge N → earliest commit output after edge N+1, i.e. one cycle of FIFO latency. There is no same-cycle bypass from MDU input to output.
- `r_write` is low in every cycle with no selected write; `rd_addr`/`rd_w_data` hold their last values.
- `alu_stall` and `mdu_ready` are combinational from state and count only, with no path from `*_valid`.
- `pend_mask` updates at the clock edge: a bit cleared by a commit at edge N drops at the same edge the write output becomes valid.
- Reset asserted mid-operation: FIFO contents are lost, and all outputs return to their reset values asynchronously.

## Structure
- Shared package `rf_pkg`: `ADDR`/`BUS_W` defaults, a `wb_req_t` struct {addr, data}, and the `wb_state_t` enum {NORMAL, DRAIN}.
- Sub-module `wb_fifo`: parameterised synchronous FIFO of `wb_req_t` with count, full and empty outputs. The arbiter, FSM and scoreboard live in the top module.

## Test plan
- Reset release, then ALU write addr 3 data 0xDEADBEEF → `r_write`=1, `rd_addr`=3, `rd_w_data`=0xDEADBEEF one cycle later. ALU write to addr 0 → `r_write` stays 0.
- `mdu_issue` addr 7, then MDU result addr 7 data 0x1234 with ALU idle → `pend_mask[7]`=1 until the commit cycle. Write appears 1 cycle after enqueue and `pend_mask[7]` returns to 0.
- Continuous ALU writes plus 4 MDU results → `mdu_ready`=0 at count 4, DRAIN entered, `alu_stall`=1. Exactly 4 FIFO commits follow in order, then NORMAL resumes and the held ALU write commits.
- FIFO at count 2 with simultaneous enqueue and dequeue for 6 cycles → count stays 2 and data order is preserved across pointer wrap.
- Commit of pending addr 5 in the same cycle as a new `mdu_issue` addr 5 → `pend_mask[5]` remains 1.
- `rst` pulled low with 3 queued entries → `r_write`=0, `pend_mask`=0 immediately. After release the first MDU result commits with no stale entries.
